// File: rtl/beam_window_ctrl.sv
// Beamformer sequencer: PDM mic clock and sample strobes, window framing with accumulator clear/latch, and steering decision with threshold and hysteresis.
// Optional window/switch statistics outputs are compiled in with `define BEAM_STATS_EN.
module beam_window_ctrl #(
  parameter int HALF_DIV     = 16,
  parameter int SAMPLE_DLY   = 2,
  parameter int WINDOW_SIZE  = 256,
  parameter int HOLD_WINDOWS = 2
) (
  input  logic               s_clk,
  input  logic               n_rst,
  input  logic               enable,
  input  logic [2:0]         energy_idx,
  input  logic signed [31:0] energy_max,
  input  logic signed [31:0] thresh,
  output logic               mic_clk,
  output logic               sample_l,
  output logic               sample_r,
  output logic               acc_clear,
  output logic               win_done,
  output logic [2:0]         best_angle,
  output logic               best_valid,
  output logic               angle_changed,
  output logic               busy
`ifdef BEAM_STATS_EN
  ,
  output logic [15:0]        win_count,
  output logic [15:0]        switch_count
`endif
);

  localparam int DIV_W = $clog2(HALF_DIV);
  localparam int PER_W = $clog2(WINDOW_SIZE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_SMP  = DIV_W'(SAMPLE_DLY);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(WINDOW_SIZE - 1);
  localparam logic [3:0]       HOLD     = 4'(HOLD_WINDOWS);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [PER_W-1:0] per_cnt, per_nxt;
  logic             mic_nxt, rose, rose_nxt, tog, fall, boundary, run;
  logic [2:0]       cand;
  logic [3:0]       cand_cnt, cnt_inc, cnt_new;
  logic             below, same_best, adopt, decide;

  // Divider and window counters advance only while running; leaving RUN/WARMUP zeroes them.
  always_comb begin
    run      = (state != IDLE) && enable;
    div_nxt  = '0;
    mic_nxt  = 1'b0;
    tog      = 1'b0;
    if (run) begin
      if (div_cnt == DIV_LAST) begin
        mic_nxt = ~mic_clk;
        tog     = 1'b1;
      end else begin
        div_nxt = div_cnt + 1'b1;
        mic_nxt = mic_clk;
      end
    end
    fall     = tog && mic_clk;
    rose_nxt = run && (rose || (tog && !mic_clk));
    boundary = fall && (per_cnt == PER_LAST);
    per_nxt  = '0;
    if (run)
      per_nxt = boundary ? '0 : (fall ? per_cnt + 1'b1 : per_cnt);
  end

  always_comb begin
    below     = energy_max < thresh;
    same_best = best_valid && (energy_idx == best_angle);
    cnt_inc   = (cand_cnt == 4'd15) ? 4'd15 : cand_cnt + 4'd1;
    cnt_new   = ((cand_cnt != 4'd0) && (energy_idx == cand)) ? cnt_inc : 4'd1;
    adopt     = (cnt_new == HOLD);
    decide    = win_done && enable;
  end

  always_ff @(posedge s_clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      per_cnt       <= '0;
      mic_clk       <= 1'b0;
      rose          <= 1'b0;
      sample_l      <= 1'b0;
      sample_r      <= 1'b0;
      acc_clear     <= 1'b0;
      win_done      <= 1'b0;
      best_angle    <= '0;
      best_valid    <= 1'b0;
      angle_changed <= 1'b0;
      busy          <= 1'b0;
      cand          <= '0;
      cand_cnt      <= '0;
    end else begin
      div_cnt       <= div_nxt;
      per_cnt       <= per_nxt;
      mic_clk       <= mic_nxt;
      rose          <= rose_nxt;
      sample_l      <= mic_nxt && (div_nxt == DIV_SMP);
      sample_r      <= !mic_nxt && (div_nxt == DIV_SMP) && rose_nxt;
      acc_clear     <= boundary;
      win_done      <= boundary && (state == RUN);
      angle_changed <= 1'b0;
      // Every state stays active while enable is high, so busy simply follows it.
      busy          <= enable;

      case (state)
        IDLE:    if (enable) state <= WARMUP;
        WARMUP:  if (!enable) state <= IDLE;
                 else if (boundary) state <= RUN;
        RUN:     if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!enable) begin
        cand_cnt <= '0;
      end else if (decide) begin
        if (below || same_best) begin
          cand_cnt <= '0;
        end else begin
          cand <= energy_idx;
          if (adopt) begin
            best_angle    <= energy_idx;
            best_valid    <= 1'b1;
            angle_changed <= 1'b1;
            cand_cnt      <= '0;
          end else begin
            cand_cnt <= cnt_new;
          end
        end
      end
    end
  end

`ifdef BEAM_STATS_EN
  always_ff @(posedge s_clk) begin
    if (!n_rst) begin
      win_count    <= '0;
      switch_count <= '0;
    end else begin
      if (boundary && (state == RUN))
        win_count <= win_count + 16'd1;
      if (decide && !below && !same_best && adopt)
        switch_count <= switch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_beam_window_ctrl.sv
// Directed bench for beam_window_ctrl: strobe/window timing, table of steering decisions, enable drop and reset corner cases.
module tb_beam_window_ctrl;
  localparam int HD = 4;
  localparam int SD = 2;
  localparam int WS = 4;
  localparam int HW = 2;
  localparam int PER = 2 * HD;
  localparam int WIN = 2 * HD * WS;

  logic              s_clk = 1'b0;
  logic              n_rst, enable;
  logic [2:0]        energy_idx;
  logic signed [31:0] energy_max, thresh;
  logic              mic_clk, sample_l, sample_r, acc_clear, win_done;
  logic [2:0]        best_angle;
  logic              best_valid, angle_changed, busy;
`ifdef BEAM_STATS_EN
  logic [15:0]       win_count, switch_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 s_clk = ~s_clk;

  beam_window_ctrl #(.HALF_DIV(HD), .SAMPLE_DLY(SD), .WINDOW_SIZE(WS), .HOLD_WINDOWS(HW)) dut (
    .s_clk(s_clk), .n_rst(n_rst), .enable(enable),
    .energy_idx(energy_idx), .energy_max(energy_max), .thresh(thresh),
    .mic_clk(mic_clk), .sample_l(sample_l), .sample_r(sample_r),
    .acc_clear(acc_clear), .win_done(win_done),
    .best_angle(best_angle), .best_valid(best_valid),
    .angle_changed(angle_changed), .busy(busy)
`ifdef BEAM_STATS_EN
    , .win_count(win_count), .switch_count(switch_count)
`endif
  );

  typedef struct {
    logic [2:0]         idx;
    logic signed [31:0] emax;
    logic signed [31:0] thr;
    logic [2:0]         best;
    logic               valid;
    logic               chg;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Enables from IDLE and checks the strobe pattern cycle by cycle; k counts cycles since WARMUP entry.
  task automatic run_timing(input int n);
    logic [5:0] got, exp;
    logic m;
    enable = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge s_clk);
      m   = ((k / HD) % 2) == 1;
      exp = {m, m && (k % HD == SD), !m && (k % HD == SD) && (k >= PER),
             (k > 0) && (k % WIN == 0), (k >= 2 * WIN) && (k % WIN == 0), 1'b1};
      got = {mic_clk, sample_l, sample_r, acc_clear, win_done, busy};
      chk("timing", {58'd0, got}, {58'd0, exp});
    end
  endtask

  task automatic wait_win();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * WIN && !seen; i++) begin
      @(negedge s_clk);
      if (win_done) seen = 1'b1;
    end
    chk("win_done_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_mic_high();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * PER && !seen; i++) begin
      @(negedge s_clk);
      if (mic_clk) seen = 1'b1;
    end
    chk("mic_high_seen", {63'd0, seen}, 64'd1);
  endtask

  initial begin
    tbl[0]  = '{3'd3,  32'sd500,   32'sd100, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{3'd3,  32'sd500,   32'sd100, 3'd3, 1'b1, 1'b1};
    tbl[2]  = '{3'd5,  32'sd500,   32'sd100, 3'd3, 1'b1, 1'b0};
    tbl[3]  = '{3'd3,  32'sd500,   32'sd100, 3'd3, 1'b1, 1'b0};
    tbl[4]  = '{3'd6,  32'sd50,    32'sd100, 3'd3, 1'b1, 1'b0};
    tbl[5]  = '{3'd6,  32'sd200,   32'sd100, 3'd3, 1'b1, 1'b0};
    tbl[6]  = '{3'd6,  32'sd200,   32'sd100, 3'd6, 1'b1, 1'b1};
    tbl[7]  = '{3'd2,  32'sd100,   32'sd100, 3'd6, 1'b1, 1'b0};
    tbl[8]  = '{3'd2,  -32'sd5,    32'sd100, 3'd6, 1'b1, 1'b0};
    tbl[9]  = '{3'd2,  32'sd100,   32'sd100, 3'd6, 1'b1, 1'b0};
    tbl[10] = '{3'd2,  32'sd100,   32'sd100, 3'd2, 1'b1, 1'b1};
    tbl[11] = '{3'd7,  32'sd5,   -32'sd1000, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{3'd7,  32'sd5,   -32'sd1000, 3'd7, 1'b1, 1'b1};
    tbl[13] = '{3'd1,  32'sd500,   32'sd100, 3'd7, 1'b1, 1'b0};
    tbl[14] = '{3'd4,  32'sd500,   32'sd100, 3'd7, 1'b1, 1'b0};
    tbl[15] = '{3'd1,  32'sd500,   32'sd100, 3'd7, 1'b1, 1'b0};
    tbl[16] = '{3'd1,  32'sd500,   32'sd100, 3'd1, 1'b1, 1'b1};

    n_rst = 1'b0; enable = 1'b0;
    energy_idx = 3'd0; energy_max = 32'sd0; thresh = 32'sd100;
    repeat (3) @(negedge s_clk);
    chk("reset_outputs",
        {52'd0, mic_clk, sample_l, sample_r, acc_clear, win_done, busy, angle_changed, best_valid, best_angle},
        64'd0);
    n_rst = 1'b1;
    @(negedge s_clk);
    chk("idle_hold", {62'd0, mic_clk, busy}, 64'd0);

    // Strobe and window timing from WARMUP entry; energies stay below threshold.
    run_timing(100);

    for (int r = 0; r < 17; r++) begin
      energy_idx = tbl[r].idx;
      energy_max = tbl[r].emax;
      thresh     = tbl[r].thr;
      wait_win();
      @(negedge s_clk);
      chk($sformatf("row%0d_best", r), {61'd0, best_angle}, {61'd0, tbl[r].best});
      chk($sformatf("row%0d_valid", r), {63'd0, best_valid}, {63'd0, tbl[r].valid});
      chk($sformatf("row%0d_changed", r), {63'd0, angle_changed}, {63'd0, tbl[r].chg});
    end

    // One candidate window for angle 5, then drop enable mid-window: candidate must be forgotten.
    energy_idx = 3'd5; energy_max = 32'sd500; thresh = 32'sd100;
    wait_win();
    @(negedge s_clk);
    chk("cand5_first", {60'd0, angle_changed, best_angle}, {60'd0, 1'b0, 3'd1});
    wait_mic_high();
    enable = 1'b0;
    @(negedge s_clk);
    chk("drop_enable", {58'd0, mic_clk, busy, best_valid, best_angle}, {58'd0, 1'b0, 1'b0, 1'b1, 3'd1});
    repeat (5) @(negedge s_clk);
    chk("idle_quiet", {60'd0, mic_clk, sample_l, acc_clear, busy}, 64'd0);

    // Re-enable: a fresh WARMUP window precedes the first win_done.
    run_timing(2 * WIN + 1);
    chk("cand_cleared", {60'd0, angle_changed, best_angle}, {60'd0, 1'b0, 3'd1});
    wait_win();
    @(negedge s_clk);
    chk("cand5_adopt", {59'd0, angle_changed, best_valid, best_angle}, {59'd0, 1'b1, 1'b1, 3'd5});

    // Reset while running with a valid decision.
    wait_mic_high();
    n_rst = 1'b0;
    @(negedge s_clk);
    chk("run_reset",
        {52'd0, mic_clk, sample_l, sample_r, acc_clear, win_done, busy, angle_changed, best_valid, best_angle},
        64'd0);
    @(negedge s_clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    n_rst = 1'b1;
    @(negedge s_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
